sd_wb_master_arb: RTL and testbench

//  Shares the single SD-controller Wishbone master port between the TX FIFO filler (reads card data

---
 rtl/sd_wb_master_arb.sv | 150 +++++++++++++++
 tb/tb_sd_wb_master_arb.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_wb_master_arb.sv
// sd_wb_master_arb: round-robin share of the SD Wishbone master port
// between the TX FIFO filler and RX FIFO emptier, with an ack watchdog.
module sd_wb_master_arb #(
    parameter int TIMEOUT_W = 8,
    parameter int TIMEOUT   = 200
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tx_cyc_i,
    input  logic        tx_stb_i,
    input  logic        tx_we_i,
    input  logic [31:0] tx_adr_i,
    output logic        tx_ack_o,
    output logic        tx_err_o,
    input  logic        rx_cyc_i,
    input  logic        rx_stb_i,
    input  logic        rx_we_i,
    input  logic [31:0] rx_adr_i,
    input  logic [31:0] rx_dat_i,
    output logic        rx_ack_o,
    output logic        rx_err_o,
    output logic [31:0] m_wb_adr_o,
    output logic [31:0] m_wb_dat_o,
    output logic        m_wb_we_o,
    output logic        m_wb_cyc_o,
    output logic        m_wb_stb_o,
    input  logic        m_wb_ack_i,
    output logic        timeout_o,
    input  logic        timeout_clr
);

    typedef enum logic [1:0] {
        IDLE,
        GNT_TX,
        GNT_RX
    } state_e;

    localparam logic [TIMEOUT_W-1:0] WDOG_LAST = TIMEOUT_W'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic                 last_rx_q, last_rx_d;
    logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
    logic                 timeout_q, timeout_d;

    logic req_tx, req_rx;
    logic gnt_tx, gnt_rx, gnt_any;
    logic sel_cyc, sel_stb;
    logic expire, abort;

    assign req_tx  = tx_cyc_i & tx_stb_i;
    assign req_rx  = rx_cyc_i & rx_stb_i;
    assign gnt_tx  = (state_q == GNT_TX);
    assign gnt_rx  = (state_q == GNT_RX);
    assign gnt_any = gnt_tx | gnt_rx;

    assign sel_cyc = (gnt_tx & tx_cyc_i) | (gnt_rx & rx_cyc_i);
    assign sel_stb = (gnt_tx & tx_stb_i) | (gnt_rx & rx_stb_i);

    // Abort only while the owner still holds its cycle; an ack in the
    // expiry cycle completes the access normally.
    assign expire = (wdog_q == WDOG_LAST);
    assign abort  = gnt_any & sel_cyc & expire & ~m_wb_ack_i;

    always_comb begin
        m_wb_adr_o = 32'd0;
        m_wb_we_o  = 1'b0;
        m_wb_dat_o = 32'd0;
        unique case (1'b1)
            gnt_tx: begin
                m_wb_adr_o = tx_adr_i;
                m_wb_we_o  = tx_we_i;
            end
            gnt_rx: begin
                m_wb_adr_o = rx_adr_i;
                m_wb_we_o  = rx_we_i;
                m_wb_dat_o = rx_dat_i;
            end
            default: ;
        endcase
    end

    assign m_wb_cyc_o = sel_cyc & ~abort;
    assign m_wb_stb_o = sel_stb & ~abort;

    assign tx_ack_o = m_wb_ack_i & gnt_tx;
    assign rx_ack_o = m_wb_ack_i & gnt_rx;
    assign tx_err_o = abort & gnt_tx;
    assign rx_err_o = abort & gnt_rx;
    assign timeout_o = timeout_q;

    always_comb begin
        state_d   = state_q;
        last_rx_d = last_rx_q;
        wdog_d    = wdog_q;
        unique case (state_q)
            IDLE: begin
                wdog_d = '0;
                if (req_tx && (!req_rx || last_rx_q)) begin
                    state_d = GNT_TX;
                end else if (req_rx) begin
                    state_d = GNT_RX;
                end
            end
            GNT_TX, GNT_RX: begin
                if (m_wb_ack_i) begin
                    state_d   = IDLE;
                    last_rx_d = gnt_rx;
                    wdog_d    = '0;
                end else if (!sel_cyc) begin
                    state_d = IDLE;
                    wdog_d  = '0;
                end else if (expire) begin
                    state_d   = IDLE;
                    last_rx_d = gnt_rx;
                    wdog_d    = '0;
                end else begin
                    wdog_d = wdog_q + TIMEOUT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                wdog_d  = '0;
            end
        endcase
    end

    always_comb begin
        timeout_d = timeout_q;
        if (abort) begin
            timeout_d = 1'b1;
        end else if (timeout_clr) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            last_rx_q <= 1'b1;
            wdog_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            last_rx_q <= last_rx_d;
            wdog_q    <= wdog_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

// File: tb/tb_sd_wb_master_arb.sv
// tb_sd_wb_master_arb: random requesters and a latency-driven slave,
// scored against a transaction-level arbitration model.
module tb_sd_wb_master_arb;

    localparam int TW   = 3;
    localparam int TO   = 4;
    localparam int NREQ = 300;

    logic        clk = 1'b0;
    logic        rst;
    logic        tx_cyc_i = 1'b0, tx_stb_i = 1'b0, tx_we_i = 1'b0;
    logic [31:0] tx_adr_i = '0;
    logic        rx_cyc_i = 1'b0, rx_stb_i = 1'b0, rx_we_i = 1'b0;
    logic [31:0] rx_adr_i = '0, rx_dat_i = '0;
    logic        m_wb_ack_i = 1'b0;
    logic        timeout_clr = 1'b0;
    logic        tx_ack_o, tx_err_o, rx_ack_o, rx_err_o;
    logic [31:0] m_wb_adr_o, m_wb_dat_o;
    logic        m_wb_we_o, m_wb_cyc_o, m_wb_stb_o, timeout_o;

    always #5 clk = ~clk;

    sd_wb_master_arb #(.TIMEOUT_W(TW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .tx_cyc_i(tx_cyc_i), .tx_stb_i(tx_stb_i), .tx_we_i(tx_we_i),
        .tx_adr_i(tx_adr_i), .tx_ack_o(tx_ack_o), .tx_err_o(tx_err_o),
        .rx_cyc_i(rx_cyc_i), .rx_stb_i(rx_stb_i), .rx_we_i(rx_we_i),
        .rx_adr_i(rx_adr_i), .rx_dat_i(rx_dat_i),
        .rx_ack_o(rx_ack_o), .rx_err_o(rx_err_o),
        .m_wb_adr_o(m_wb_adr_o), .m_wb_dat_o(m_wb_dat_o),
        .m_wb_we_o(m_wb_we_o), .m_wb_cyc_o(m_wb_cyc_o),
        .m_wb_stb_o(m_wb_stb_o), .m_wb_ack_i(m_wb_ack_i),
        .timeout_o(timeout_o), .timeout_clr(timeout_clr)
    );

    typedef struct {
        bit          rx;
        logic [31:0] adr;
        logic        we;
        logic [31:0] dat;
        bit          err;
        int          first;
        int          done;
    } acc_t;

    acc_t        exp_q[$];
    int unsigned vec = 0;
    int unsigned bad = 0;
    int          cnum = 0;
    bit          run = 1'b0;
    bit          tmo_exp = 1'b0;
    int          lat[NREQ+8];
    int          issued = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cnum, act, exp);
        end
    endtask

    task automatic chk_quiet(input string nm);
        chk({nm, "_cyc"}, m_wb_cyc_o, 0);
        chk({nm, "_stb"}, m_wb_stb_o, 0);
        chk({nm, "_ack"}, {tx_ack_o, rx_ack_o}, 0);
        chk({nm, "_err"}, {tx_err_o, rx_err_o}, 0);
    endtask

    // Reference: an access occupies min(L, TO-1)+1 cycles, then one idle
    // cycle; round-robin picks the requester that did not go last.
    initial begin
        bit   last_rx;
        bit   rt, rr;
        int   free_at, k, err_at, l;
        acc_t a;
        last_rx = 1'b1;
        free_at = 0;
        k = 0;
        err_at = -1;
        forever begin
            @(posedge clk);
            if (!run) continue;
            if (err_at == cnum) tmo_exp = 1'b1;
            else if (timeout_clr) tmo_exp = 1'b0;
            cnum++;
            if (cnum < free_at) continue;
            rt = tx_cyc_i && tx_stb_i;
            rr = rx_cyc_i && rx_stb_i;
            if (!(rt || rr)) continue;
            l = lat[k];
            k++;
            a.rx    = rr && (!rt || !last_rx);
            last_rx = a.rx;
            a.adr   = a.rx ? rx_adr_i : tx_adr_i;
            a.we    = a.rx ? rx_we_i : tx_we_i;
            a.dat   = a.rx ? rx_dat_i : 32'd0;
            a.err   = (l >= TO);
            a.first = cnum;
            a.done  = cnum + (a.err ? TO - 1 : l);
            free_at = a.done + 2;
            err_at  = a.err ? a.done : -1;
            exp_q.push_back(a);
        end
    end

    initial begin
        acc_t a;
        forever begin
            @(negedge clk);
            if (!run) continue;
            if (exp_q.size() > 0 && cnum >= exp_q[0].first) begin
                a = exp_q[0];
                chk("adr", m_wb_adr_o, a.adr);
                chk("we", m_wb_we_o, a.we);
                chk("dat", m_wb_dat_o, a.dat);
                if (cnum == a.done) begin
                    chk("tx_ack", tx_ack_o, !a.rx && !a.err);
                    chk("rx_ack", rx_ack_o, a.rx && !a.err);
                    chk("tx_err", tx_err_o, !a.rx && a.err);
                    chk("rx_err", rx_err_o, a.rx && a.err);
                    chk("end_cyc", m_wb_cyc_o, !a.err);
                    chk("end_stb", m_wb_stb_o, !a.err);
                    void'(exp_q.pop_front());
                end else begin
                    chk("act_cyc", m_wb_cyc_o, 1);
                    chk("act_stb", m_wb_stb_o, 1);
                    chk("act_ack", {tx_ack_o, rx_ack_o}, 0);
                    chk("act_err", {tx_err_o, rx_err_o}, 0);
                end
            end else begin
                chk_quiet("idle");
            end
            chk("timeout", timeout_o, tmo_exp);
        end
    end

    task automatic new_tx();
        tx_cyc_i = 1'b1;
        tx_stb_i = 1'b1;
        tx_we_i  = 1'($urandom_range(0, 1));
        tx_adr_i = $urandom;
        issued++;
    endtask

    task automatic new_rx();
        rx_cyc_i = 1'b1;
        rx_stb_i = 1'b1;
        rx_we_i  = 1'($urandom_range(0, 1));
        rx_adr_i = $urandom;
        rx_dat_i = $urandom;
        issued++;
    endtask

    initial begin
        bit tx_done, rx_done;
        int tx_gap, rx_gap, scnt, cur_lat, ai, c;
        tx_done = 0; rx_done = 0;
        tx_gap = 0; rx_gap = 0;
        scnt = 0; cur_lat = 0; ai = 0;
        for (int i = 0; i < NREQ + 8; i++) begin
            if ($urandom_range(0, 3) == 0) lat[i] = $urandom_range(TO, TO + 2);
            else lat[i] = $urandom_range(1, TO - 1);
        end
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("rst");
        chk("rst_timeout", timeout_o, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        run = 1'b1;

        c = 0;
        while (c < 6000 && !(issued >= NREQ && !tx_cyc_i && !rx_cyc_i
                             && exp_q.size() == 0)) begin
            c++;
            @(negedge clk);
            if (tx_ack_o || tx_err_o) tx_done = 1;
            if (rx_ack_o || rx_err_o) rx_done = 1;
            if (m_wb_cyc_o && m_wb_stb_o) begin
                if (scnt == 0) begin
                    cur_lat = (ai < NREQ + 8) ? lat[ai] : 1;
                    ai++;
                end
                scnt++;
            end else begin
                scnt = 0;
            end
            @(posedge clk);
            #1;
            m_wb_ack_i = (scnt != 0) && (scnt == cur_lat);
            if (tx_done) begin
                tx_done = 0;
                if (issued < NREQ && $urandom_range(0, 2) == 0) new_tx();
                else begin
                    tx_cyc_i = 0; tx_stb_i = 0;
                    tx_gap = $urandom_range(0, 3);
                end
            end else if (!tx_cyc_i) begin
                if (tx_gap > 0) tx_gap--;
                else if (issued < NREQ) new_tx();
            end
            if (rx_done) begin
                rx_done = 0;
                if (issued < NREQ && $urandom_range(0, 2) == 0) new_rx();
                else begin
                    rx_cyc_i = 0; rx_stb_i = 0;
                    rx_gap = $urandom_range(0, 3);
                end
            end else if (!rx_cyc_i) begin
                if (rx_gap > 0) rx_gap--;
                else if (issued < NREQ) new_rx();
            end
            timeout_clr = ($urandom_range(0, 5) == 0);
        end
        chk("drained", exp_q.size(), 0);
        chk("all_issued", issued >= NREQ, 1);

        // Directed: reset in GNT_RX, then tie after reset, then watchdog.
        run = 1'b0;
        m_wb_ack_i = 0; timeout_clr = 0;
        tx_cyc_i = 0; tx_stb_i = 0; rx_cyc_i = 0; rx_stb_i = 0;
        repeat (3) @(posedge clk);
        #1;
        rx_cyc_i = 1; rx_stb_i = 1; rx_we_i = 1;
        rx_adr_i = 32'hA000_0010; rx_dat_i = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        chk("d_rx_cyc", m_wb_cyc_o, 1);
        chk("d_rx_adr", m_wb_adr_o, 32'hA000_0010);
        #1 rst = 1'b0;
        m_wb_ack_i = 1;
        #1;
        chk_quiet("d_rst");
        chk("d_rst_timeout", timeout_o, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        m_wb_ack_i = 0;
        tx_cyc_i = 1; tx_stb_i = 1; tx_we_i = 0; tx_adr_i = 32'hB000_0020;
        @(negedge clk);
        chk_quiet("d_idle0");
        @(negedge clk);
        chk("d_tie_adr", m_wb_adr_o, 32'hB000_0020);
        chk("d_tie_dat", m_wb_dat_o, 0);
        m_wb_ack_i = 1;
        #1;
        chk("d_tx_ack", {tx_ack_o, rx_ack_o}, 2'b10);
        @(posedge clk);
        #1 m_wb_ack_i = 0;
        @(negedge clk);
        chk_quiet("d_gap");
        @(negedge clk);
        chk("d_rx_adr2", m_wb_adr_o, 32'hA000_0010);
        chk("d_rx_we", m_wb_we_o, 1);
        chk("d_rx_dat", m_wb_dat_o, 32'hDEAD_BEEF);
        m_wb_ack_i = 1;
        #1;
        chk("d_rx_ack", {tx_ack_o, rx_ack_o}, 2'b01);
        @(posedge clk);
        #1 m_wb_ack_i = 0;
        rx_cyc_i = 0; rx_stb_i = 0;
        @(negedge clk);
        chk_quiet("d_gap2");
        for (int g = 0; g < TO; g++) begin
            @(negedge clk);
            chk("d_wd_err", tx_err_o, g == TO - 1);
            chk("d_wd_cyc", m_wb_cyc_o, g != TO - 1);
            chk("d_wd_tmo", timeout_o, 0);
        end
        @(posedge clk);
        #1 tx_cyc_i = 0; tx_stb_i = 0;
        timeout_clr = 1;
        @(negedge clk);
        chk("d_tmo_set", timeout_o, 1);
        @(posedge clk);
        #1 timeout_clr = 0;
        @(negedge clk);
        chk("d_tmo_clr", timeout_o, 0);
        chk_quiet("d_end");

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule
